// File: rtl/eccdh_host_pkg.sv
// Shared types and helpers for the ECC-DH/3DES host-side sequencer.
package eccdh_host_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEND_WORD,
      GAP,
      WAIT_ECC,
      DATA_IDLE,
      WAIT_BLK,
      OUT_HOLD,
      ERROR
   } host_state_e;

   localparam logic [2:0] MODE_DATA = 3'd5;
   localparam logic [2:0] MODE_ERR  = 3'd7;

   localparam int KEY_W   = 164;
   localparam int WORD_W  = 64;
   localparam int N_WORDS = 9;

   localparam logic [3:0] LAST_IDX = 4'(N_WORDS - 1);

   // Words go k, x, y; each value least-significant word first, top word zero-padded.
   function automatic logic [WORD_W-1:0] get_word(input logic [KEY_W-1:0] k,
                                                  input logic [KEY_W-1:0] x,
                                                  input logic [KEY_W-1:0] y,
                                                  input logic [3:0]       idx);
      logic [KEY_W-1:0]  v;
      logic [WORD_W-1:0] w;
      case (idx)
         4'd0, 4'd1, 4'd2: v = k;
         4'd3, 4'd4, 4'd5: v = x;
         default:          v = y;
      endcase
      case (idx)
         4'd0, 4'd3, 4'd6: w = v[63:0];
         4'd1, 4'd4, 4'd7: w = v[127:64];
         default:          w = {28'b0, v[163:128]};
      endcase
      return w;
   endfunction

endpackage

// File: rtl/eccdh_watchdog.sv
// 20-bit watchdog: reloads while cleared, counts down while enabled, flags terminal count.
module eccdh_watchdog #(
   parameter int unsigned TIMEOUT = 1048575
) (
   input  logic clk,
   input  logic n_rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [19:0] LOAD = 20'(TIMEOUT - 1);

   logic [19:0] cnt_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= LOAD;
      end else if (enable && (cnt_q != 20'd0)) begin
         cnt_q <= cnt_q - 20'd1;
      end
   end

   assign expired = enable && (cnt_q == 20'd0);

endmodule

// File: rtl/eccdh_host_seq.sv
// Host-side initiator for the ECC-DH/3DES core: key/point word loading, then block streaming.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | no key loaded, waiting for cfg
// SEND_WORD | one-cycle strobe of key/point word idx
// GAP       | idle spacing between word strobes
// WAIT_ECC  | waiting for core to reach data mode (watchdog running)
// DATA_IDLE | keyed, ready for a block or a re-key
// WAIT_BLK  | block sent, waiting for core result (watchdog running)
// OUT_HOLD  | result presented, waiting for consumer
// ERROR     | core error or timeout, sticky until cfg
module eccdh_host_seq
   import eccdh_host_pkg::*;
#(
   parameter int unsigned WORD_GAP = 2,
   parameter int unsigned TIMEOUT  = 1048575
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [KEY_W-1:0]  cfg_k,
   input  logic [KEY_W-1:0]  cfg_px,
   input  logic [KEY_W-1:0]  cfg_py,
   input  logic              cfg_encrypt,
   input  logic              blk_in_valid,
   output logic              blk_in_ready,
   input  logic [WORD_W-1:0] blk_in,
   output logic              blk_out_valid,
   input  logic              blk_out_ready,
   output logic [WORD_W-1:0] blk_out,
   output logic              busy,
   output logic              err,
   output logic [WORD_W-1:0] core_data_in,
   output logic              core_start,
   output logic              core_is_encrypt,
   input  logic [2:0]        core_mode,
   input  logic              core_data_ready,
   input  logic [WORD_W-1:0] core_data_out
);

   host_state_e       state_q, state_n;
   logic [3:0]        idx_q, idx_n;
   logic [15:0]       gap_q;
   logic [KEY_W-1:0]  k_q, x_q, y_q;
   logic              enc_q;
   logic [WORD_W-1:0] data_q;
   logic              start_q;
   logic [WORD_W-1:0] blk_out_q;
   logic              cfg_acc, blk_acc;
   logic              wd_en, wd_exp;

   assign cfg_ready    = (state_q == IDLE) || (state_q == DATA_IDLE) || (state_q == ERROR);
   assign blk_in_ready = (state_q == DATA_IDLE) && !cfg_valid;
   assign cfg_acc      = cfg_valid && cfg_ready;
   assign blk_acc      = blk_in_valid && blk_in_ready;
   assign wd_en        = (state_q == WAIT_ECC) || (state_q == WAIT_BLK);

   eccdh_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .n_rst   (n_rst),
      .clear   (!wd_en),
      .enable  (wd_en),
      .expired (wd_exp)
   );

   always_comb begin
      state_n = state_q;
      idx_n   = idx_q;
      unique case (state_q)
         IDLE, ERROR: begin
            if (cfg_acc) begin
               state_n = SEND_WORD;
               idx_n   = 4'd0;
            end
         end
         SEND_WORD: begin
            if (idx_q == LAST_IDX) begin
               state_n = WAIT_ECC;
            end else begin
               idx_n   = idx_q + 4'd1;
               state_n = (WORD_GAP == 0) ? SEND_WORD : GAP;
            end
         end
         GAP: begin
            if (gap_q == 16'd0) state_n = SEND_WORD;
         end
         WAIT_ECC: begin
            if (wd_exp)                       state_n = ERROR;
            else if (core_mode == MODE_DATA)  state_n = DATA_IDLE;
         end
         DATA_IDLE: begin
            if (cfg_acc) begin
               state_n = SEND_WORD;
               idx_n   = 4'd0;
            end else if (blk_acc) begin
               state_n = WAIT_BLK;
            end
         end
         WAIT_BLK: begin
            if (wd_exp)               state_n = ERROR;
            else if (core_data_ready) state_n = OUT_HOLD;
         end
         OUT_HOLD: begin
            if (blk_out_ready) state_n = DATA_IDLE;
         end
         default: state_n = IDLE;
      endcase
      // A core error overrides whatever the sequence was doing.
      if ((core_mode == MODE_ERR) && (state_q != IDLE) && (state_q != ERROR)) begin
         state_n = ERROR;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         gap_q     <= '0;
         k_q       <= '0;
         x_q       <= '0;
         y_q       <= '0;
         enc_q     <= 1'b0;
         data_q    <= '0;
         start_q   <= 1'b0;
         blk_out_q <= '0;
      end else begin
         state_q <= state_n;
         idx_q   <= idx_n;
         start_q <= 1'b0;
         if (cfg_acc) begin
            k_q   <= cfg_k;
            x_q   <= cfg_px;
            y_q   <= cfg_py;
            enc_q <= cfg_encrypt;
         end
         // Strobe and data are registered so they line up with the SEND_WORD / WAIT_BLK cycle.
         if (state_n == SEND_WORD) begin
            start_q <= 1'b1;
            data_q  <= cfg_acc ? get_word(cfg_k, cfg_px, cfg_py, 4'd0)
                               : get_word(k_q, x_q, y_q, idx_n);
         end else if ((state_q == DATA_IDLE) && (state_n == WAIT_BLK)) begin
            start_q <= 1'b1;
            data_q  <= blk_in;
         end
         if (state_q == SEND_WORD) begin
            gap_q <= 16'(WORD_GAP - 1);
         end else if ((state_q == GAP) && (gap_q != 16'd0)) begin
            gap_q <= gap_q - 16'd1;
         end
         if ((state_q == WAIT_BLK) && (state_n == OUT_HOLD)) begin
            blk_out_q <= core_data_out;
         end
      end
   end

   assign core_data_in    = data_q;
   assign core_start      = start_q;
   assign core_is_encrypt = enc_q;
   assign blk_out         = blk_out_q;
   assign blk_out_valid   = (state_q == OUT_HOLD);
   assign busy            = (state_q != IDLE) && (state_q != DATA_IDLE);
   assign err             = (state_q == ERROR);

endmodule

// File: tb/tb_eccdh_host_seq.sv
// Directed bench for eccdh_host_seq: key load, block round trip, re-key priority, errors, reset.
module tb_eccdh_host_seq;

   logic          clk;
   logic          n_rst;
   logic          cfg_valid, cfg_valid2;
   logic [163:0]  cfg_k, cfg_px, cfg_py;
   logic          cfg_encrypt;
   logic          blk_in_valid;
   logic [63:0]   blk_in;
   logic          blk_out_ready;
   logic [2:0]    core_mode, core_mode2;
   logic          core_data_ready;
   logic [63:0]   core_data_out;

   logic          cfg_ready, blk_in_ready, blk_out_valid, busy, err, core_start, core_is_encrypt;
   logic [63:0]   blk_out, core_data_in;
   logic          cfg_ready2, blk_in_ready2, blk_out_valid2, busy2, err2, core_start2, core_is_encrypt2;
   logic [63:0]   blk_out2, core_data_in2;

   int n_checks = 0;
   int n_fail   = 0;

   eccdh_host_seq #(.WORD_GAP(2)) dut (
      .clk(clk), .n_rst(n_rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_k(cfg_k), .cfg_px(cfg_px), .cfg_py(cfg_py), .cfg_encrypt(cfg_encrypt),
      .blk_in_valid(blk_in_valid), .blk_in_ready(blk_in_ready), .blk_in(blk_in),
      .blk_out_valid(blk_out_valid), .blk_out_ready(blk_out_ready), .blk_out(blk_out),
      .busy(busy), .err(err),
      .core_data_in(core_data_in), .core_start(core_start), .core_is_encrypt(core_is_encrypt),
      .core_mode(core_mode), .core_data_ready(core_data_ready), .core_data_out(core_data_out)
   );

   eccdh_host_seq #(.WORD_GAP(2), .TIMEOUT(100)) dut_to (
      .clk(clk), .n_rst(n_rst),
      .cfg_valid(cfg_valid2), .cfg_ready(cfg_ready2),
      .cfg_k(cfg_k), .cfg_px(cfg_px), .cfg_py(cfg_py), .cfg_encrypt(cfg_encrypt),
      .blk_in_valid(blk_in_valid), .blk_in_ready(blk_in_ready2), .blk_in(blk_in),
      .blk_out_valid(blk_out_valid2), .blk_out_ready(blk_out_ready), .blk_out(blk_out2),
      .busy(busy2), .err(err2),
      .core_data_in(core_data_in2), .core_start(core_start2), .core_is_encrypt(core_is_encrypt2),
      .core_mode(core_mode2), .core_data_ready(core_data_ready), .core_data_out(core_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [63:0] exp_w [9];
   int          st_cyc [9];
   logic [63:0] st_dat [9];
   int          ns;
   logic        seen;

   initial begin
      #300000;
      $display("FAIL tb_timeout: got no finish expected finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      exp_w = '{64'h1, 64'h0, 64'h0,
                64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0000_000A_AAAA_AAAA,
                64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555, 64'h0000_0005_5555_5555};
      for (int i = 0; i < 9; i++) begin
         st_cyc[i] = 0;
         st_dat[i] = '0;
      end
      n_rst = 1'b0;
      cfg_valid = 1'b0; cfg_valid2 = 1'b0;
      cfg_k = '0; cfg_px = '0; cfg_py = '0; cfg_encrypt = 1'b0;
      blk_in_valid = 1'b0; blk_in = '0; blk_out_ready = 1'b0;
      core_mode = 3'd0; core_mode2 = 3'd0;
      core_data_ready = 1'b0; core_data_out = '0;
      repeat (2) tick();

      check_eq("rst_cfg_ready",    64'(cfg_ready),       64'd1);
      check_eq("rst_busy",         64'(busy),            64'd0);
      check_eq("rst_err",          64'(err),             64'd0);
      check_eq("rst_core_start",   64'(core_start),      64'd0);
      check_eq("rst_core_data_in", core_data_in,         64'd0);
      check_eq("rst_blk_out",      blk_out,              64'd0);
      check_eq("rst_blk_out_vld",  64'(blk_out_valid),   64'd0);
      check_eq("rst_blk_in_ready", 64'(blk_in_ready),    64'd0);
      n_rst = 1'b1;
      tick();

      // key load: cycle c=1 is the cycle after accept
      cfg_k = 164'h1; cfg_px = {41{4'hA}}; cfg_py = {41{4'h5}}; cfg_encrypt = 1'b1;
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      ns = 0;
      for (int c = 1; c <= 27; c++) begin
         if (core_start) begin
            if (ns < 9) begin
               st_cyc[ns] = c;
               st_dat[ns] = core_data_in;
            end
            ns++;
         end
         if (c < 27) tick();
      end
      check_eq("n_word_strobes", 64'(ns), 64'd9);
      for (int n = 0; n < 9; n++) begin
         check_eq($sformatf("strobe_cyc%0d", n), 64'(st_cyc[n]), 64'(1 + 3 * n));
         check_eq($sformatf("word%0d", n), st_dat[n], exp_w[n]);
      end
      check_eq("wait_ecc_busy",    64'(busy),            64'd1);
      check_eq("data_in_hold",     core_data_in,         64'h0000_0005_5555_5555);
      check_eq("encrypt_latched",  64'(core_is_encrypt), 64'd1);

      repeat (1000) tick();
      check_eq("ecc_wait_no_ready", 64'(blk_in_ready), 64'd0);
      core_mode = 3'd5;
      tick();
      check_eq("data_mode_ready", 64'(blk_in_ready), 64'd1);
      check_eq("data_mode_busy",  64'(busy),         64'd0);

      // block round trip
      blk_in = 64'h0123_4567_89AB_CDEF; blk_in_valid = 1'b1;
      tick();
      blk_in_valid = 1'b0;
      check_eq("blk_start",       64'(core_start),   64'd1);
      check_eq("blk_data_in",     core_data_in,      64'h0123_4567_89AB_CDEF);
      check_eq("blk_busy",        64'(busy),         64'd1);
      check_eq("blk_ready_low",   64'(blk_in_ready), 64'd0);
      tick();
      check_eq("blk_start_1cyc",  64'(core_start),   64'd0);
      repeat (38) tick();
      core_data_ready = 1'b1; core_data_out = 64'hDEAD_BEEF_0000_0001;
      tick();
      core_data_ready = 1'b0; core_data_out = 64'hFFFF_FFFF_FFFF_FFFF;
      check_eq("out_valid",       64'(blk_out_valid), 64'd1);
      check_eq("out_data",        blk_out,            64'hDEAD_BEEF_0000_0001);
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq($sformatf("out_hold_data%0d", i),  blk_out,            64'hDEAD_BEEF_0000_0001);
         check_eq($sformatf("out_hold_valid%0d", i), 64'(blk_out_valid), 64'd1);
      end
      blk_out_ready = 1'b1;
      tick();
      blk_out_ready = 1'b0;
      check_eq("post_out_valid",  64'(blk_out_valid), 64'd0);
      check_eq("post_out_busy",   64'(busy),          64'd0);
      check_eq("post_out_ready",  64'(blk_in_ready),  64'd1);

      // stray data_ready outside WAIT_BLK
      core_data_ready = 1'b1; core_data_out = 64'h1234_5678_9ABC_DEF0;
      tick();
      core_data_ready = 1'b0;
      check_eq("stray_valid",     64'(blk_out_valid), 64'd0);
      check_eq("stray_blk_out",   blk_out,            64'hDEAD_BEEF_0000_0001);
      check_eq("stray_busy",      64'(busy),          64'd0);

      // cfg and block together: cfg wins, block is not sent
      cfg_k = {100'h0, 64'h1111_2222_3333_4444}; cfg_encrypt = 1'b0;
      cfg_valid = 1'b1; blk_in_valid = 1'b1; blk_in = 64'hCAFE_F00D_CAFE_F00D;
      #1;
      check_eq("both_blk_ready",  64'(blk_in_ready), 64'd0);
      tick();
      cfg_valid = 1'b0; blk_in_valid = 1'b0;
      check_eq("rekey_start",     64'(core_start),      64'd1);
      check_eq("rekey_word0",     core_data_in,         64'h1111_2222_3333_4444);
      check_eq("rekey_decrypt",   64'(core_is_encrypt), 64'd0);
      seen = 1'b0; ns = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         tick();
         if (core_start) ns++;
         seen = blk_in_ready;
      end
      check_eq("rekey_done",      64'(seen), 64'd1);
      check_eq("rekey_strobes",   64'(ns),   64'd8);

      // core error during GAP
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      check_eq("err_seq_start",   64'(core_start), 64'd1);
      tick();
      core_mode = 3'd7;
      tick();
      check_eq("err_set",         64'(err),       64'd1);
      check_eq("err_busy",        64'(busy),      64'd1);
      check_eq("err_cfg_ready",   64'(cfg_ready), 64'd1);
      ns = 0;
      for (int i = 0; i < 10; i++) begin
         if (core_start) ns++;
         tick();
      end
      check_eq("err_no_strobes",  64'(ns),  64'd0);
      check_eq("err_sticky",      64'(err), 64'd1);

      // recover via cfg, then reset during WAIT_BLK
      core_mode = 3'd5; cfg_encrypt = 1'b1; cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      check_eq("err_cleared",     64'(err),        64'd0);
      check_eq("recover_start",   64'(core_start), 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         tick();
         seen = blk_in_ready;
      end
      check_eq("recover_keyed",   64'(seen), 64'd1);
      blk_in = 64'h0F0F_0F0F_0F0F_0F0F; blk_in_valid = 1'b1;
      tick();
      blk_in_valid = 1'b0;
      check_eq("blk2_start",      64'(core_start), 64'd1);
      tick();
      check_eq("blk2_busy",       64'(busy),       64'd1);
      #2;
      n_rst = 1'b0;
      #1;
      check_eq("arst_cfg_ready",  64'(cfg_ready),       64'd1);
      check_eq("arst_busy",       64'(busy),            64'd0);
      check_eq("arst_data_in",    core_data_in,         64'd0);
      check_eq("arst_blk_out",    blk_out,              64'd0);
      check_eq("arst_encrypt",    64'(core_is_encrypt), 64'd0);
      check_eq("arst_start",      64'(core_start),      64'd0);
      tick();
      n_rst = 1'b1;
      tick();
      check_eq("post_rst_idle",   64'(busy), 64'd0);

      // watchdog on the TIMEOUT=100 instance
      cfg_valid2 = 1'b1;
      tick();
      cfg_valid2 = 1'b0;
      check_eq("to_start",        64'(core_start2), 64'd1);
      repeat (24) tick();
      check_eq("to_last_word",    64'(core_start2), 64'd1);
      tick();
      check_eq("to_wait_busy",    64'(busy2), 64'd1);
      repeat (99) tick();
      check_eq("to_before_limit", 64'(err2), 64'd0);
      tick();
      check_eq("to_at_limit",     64'(err2), 64'd1);
      cfg_valid2 = 1'b1;
      tick();
      cfg_valid2 = 1'b0;
      check_eq("to_cleared",      64'(err2),        64'd0);
      check_eq("to_rekey_start",  64'(core_start2), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/eccdh_host_seq.md
# eccdh_host_seq

Host-side initiator for the ECC-DH/3DES core's word interface. It drives the core's `data_in`/`start` inputs and monitors its `mode`/`data_ready`/`data_out` outputs. It serializes a 164-bit private key and an input point into 64-bit words, waits for the shared-key derivation, then streams 64-bit blocks through 3DES and returns the results over valid/ready handshakes. It sits between the system bus adapter and the core.

## Interface
- `WORD_GAP`, default 2: idle cycles between consecutive key/point word pulses.
- `TIMEOUT`, default 1048575: watchdog limit in cycles; the counter is 20 bits wide.
- `clk`  in  1  system clock.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `cfg_valid` / `cfg_ready`  in / out  1 / 1  key-load handshake.
- `cfg_k`, `cfg_px`, `cfg_py`  in  164 each  private scalar and point x/y.
- `cfg_encrypt`  in  1  direction, latched on cfg accept.
- `blk_in_valid` / `blk_in_ready`  in / out  1 / 1  input block handshake.
- `blk_in`  in  64  plaintext or ciphertext block.
- `blk_out_valid` / `blk_out_ready`  out / in  1 / 1  result handshake.
- `blk_out`  out  64  result block.
- `busy`  out  1  high in every state except IDLE and DATA_IDLE.
- `err`  out  1  high while in ERROR.
- `core_data_in`  out  64  word to core.
- `core_start`  out  1  one-cycle word/block strobe.
- `core_is_encrypt`  out  1  latched direction.
- `core_mode`  in  3  core mode.
- `core_data_ready`  in  1  core result strobe.
- `core_data_out`  in  64  core result.

## Operation
- States: IDLE, SEND_WORD, GAP, WAIT_ECC, DATA_IDLE, WAIT_BLK, OUT_HOLD, ERROR.
- `cfg_ready` is high in IDLE, DATA_IDLE and ERROR.
- On cfg accept:
  - Latch k/px/py/encrypt.
  - Clear the word index.
  - Go to SEND_WORD.
- Word order is 9 words: k, then x, then y. Each value is sent as 3 words, least-significant word first:
  - w0 = v[63:0]
  - w1 = v[127:64]
  - w2 = {28'b0, v[163:128]}
- SEND_WORD: `core_start`=1 and `core_data_in`=word[idx] for exactly one cycle.
  - If idx<8: go to GAP for WORD_GAP cycles, then back to SEND_WORD with idx+1.
  - If idx=8: go to WAIT_ECC.
- WAIT_ECC: when `core_mode`==MODE_DATA (5), go to DATA_IDLE.
- DATA_IDLE: `blk_in_ready` = !`cfg_valid`.
  - cfg has priority: it re-keys the core and returns to SEND_WORD.
  - On blk accept: `core_data_in`=`blk_in` and `core_start`=1 for one cycle, then go to WAIT_BLK.
- WAIT_BLK: on `core_data_ready`, capture `core_data_out` into `blk_out`, raise `blk_out_valid`, and go to OUT_HOLD.
- OUT_HOLD: hold `blk_out`/`blk_out_valid` stable until `blk_out_ready`, then go to DATA_IDLE.
- `core_data_in` holds its last driven value between strobes.
- `core_data_ready` outside WAIT_BLK is ignored; no capture, no state change.
- `core_mode`==MODE_ERR (7) in any state other than IDLE or ERROR: go to ERROR.
- Watchdog: cleared on entry to WAIT_ECC and WAIT_BLK, increments each cycle in those states. Reaching TIMEOUT: go to ERROR.
- ERROR is sticky; only a cfg accept or reset leaves it.

## Timing
- Reset: state=IDLE. Output values during reset:
  - `cfg_ready`=1
  - all other outputs 0
  - `core_data_in`=0, `blk_out`=0
- cfg accepted in cycle T: word n is strobed in cycle T+1+n·(WORD_GAP+1). With WORD_GAP=2, the last word is at T+25 and WAIT_ECC begins at T+26.
- `core_mode` seen as 5 in cycle M: `blk_in_ready`=1 from M+1.
- Block accepted in T: `core_start` is high in T+1.
- `core_data_ready` in U: `blk_out_valid` is high from U+1, `busy`=0 and `blk_in_ready` from the cycle after `blk_out_ready` handshake.
- Throughput is one block per round trip; there is no overlap of input and output.
- `n_rst` asserted mid-sequence: immediate return to IDLE, no further `core_start`, all latched data cleared.

## Structure
- Package `eccdh_host_pkg`:
  - state enum
  - MODE_DATA=3'd5 and MODE_ERR=3'd7
  - KEY_W=164, WORD_W=64, N_WORDS=9
  - word-slicing function `get_word(k,x,y,idx)`
- Sub-module `eccdh_watchdog`: 20-bit counter with `clear`/`enable`/`expired`. All else is one FSM module.

## Test plan
- k=164'h1, px=164'hA…A, py=164'h5…5, WORD_GAP=2:
  - nine `core_start` pulses 3 cycles apart
  - word2 of k = 64'h0
  - word0 of px = 64'hAAAA_AAAA_AAAA_AAAA
- Core model asserts `core_mode`=5 after 1000 cycles, then blk_in=64'h0123_4567_89AB_CDEF; model returns data_ready 40 cycles later with 64'hDEAD_BEEF_0000_0001:
  - `blk_out` equals that value one cycle after data_ready
  - `blk_out` is held through 5 cycles of `blk_out_ready`=0
- `cfg_valid` and `blk_in_valid` high together in DATA_IDLE: `blk_in_ready`=0, re-key starts, and the block is not sent.
- TIMEOUT=100 with `core_mode` stuck at 0: `err`=1 exactly 100 cycles after WAIT_ECC entry, and a later cfg accept clears it.
- `core_mode`=7 during GAP: ERROR next cycle with no further strobes. `n_rst` pulsed during WAIT_BLK: all outputs return to reset values asynchronously.
